hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
// - Execute-stage HI/LO register unit downstream of the 16x16 multiplier; captures {upper,lower} product halves.
// - Models multiplier latency with a MUL_LAT-deep in-flight pipe, then retires into HI/LO.
// - Services MTHI/MTLO writes and MFHI/MFLO reads; raises a stall interlock on read-after-multiply hazards.
// PARAMETERS
// - DATA_W   16  width of HI, LO, product halves and move data
// - MUL_LAT  2   cycles from mul_valid capture to HI/LO update (legal >= 1)
// PORTS
// - clk       in   1       rising-edge clock (single clock domain)
// - rst_n     in   1       asynchronous active-low reset
// - mul_valid in   1       product on mul_hi/mul_lo is valid; captured this edge
// - mul_hi    in   DATA_W  upper product half (bits 31:16)
// - mul_lo    in   DATA_W  lower product half (bits 15:0)
// - mthi_en   in   1       write mt_data to HI
// - mtlo_en   in   1       write mt_data to LO
// - mt_data   in   DATA_W  move-to data
// - mfhi_req  in   1       read HI; held by upstream while stall=1
// - mflo_req  in   1       read LO; held by upstream while stall=1
// - rd_data   out  DATA_W  registered read result
// - rd_valid  out  1       rd_data valid; 1-cycle pulse
// - stall     out  1       combinational; read request not accepted this cycle
// - hi        out  DATA_W  architectural HI
// - lo        out  DATA_W  architectural LO
// - busy      out  1       any in-flight entry valid
// BEHAVIOUR
// - Reset (async, rst_n=0): hi=lo=0, rd_data=0, rd_valid=0, all pipe entries invalid; stall/busy=0. Reset mid-operation discards in-flight products.
// - Pipe: shift register of MUL_LAT entries {valid, hi_we, lo_we, hi, lo}; mul_valid loads stage 0 with hi_we=lo_we=1; entry at last stage retires next edge.
// - Back-to-back mul_valid every cycle legal; results retire in issue order, one per cycle.
// - Retirement: HI<=entry.hi if hi_we, LO<=entry.lo if lo_we; products are unsigned concatenation, no truncation.
// - MTHI (MTLO): clears hi_we (lo_we) in every in-flight entry same edge, so older products never overwrite the newer move.
// - MT and retirement same edge: MT wins for its half; other half retires normally.
// - mthi_en and mtlo_en together: both written with mt_data.
// - mul_valid with MT same cycle: MT is older; new entry keeps hi_we=lo_we=1.
// - Hazard: mf*_req while busy=1 -> stall=1, no rd_valid; accepted the cycle stall=0.
// - Accepted read: rd_data<=selected register, rd_valid=1 next cycle (latency 1). mfhi_req and mflo_req together: HI returned, LO request dropped.
// - Read with MT same cycle (no forwarding): returns pre-MT value.
// - busy = OR of entry valids; stall = (mfhi_req|mflo_req) & hazard.
// CONFIGURATION
// - HILO_FWD_EN defined: bypass. No stall when only valid entry is the last stage retiring this cycle; rd_data takes the retiring half (if its we set). Same-cycle MT to the read half forwards mt_data (MT priority over retiring value).
// - HILO_FWD_EN undefined: stall while any entry valid, including the retiring one; reads see registered hi/lo only (one extra stall cycle vs bypass).
// STRUCTURE
// - hilo_pkg: DATA_W default, hilo_entry_t struct {valid,hi_we,lo_we,hi,lo}, MUL_LAT default constant.
// - Sub-module hilo_pipe: parameterised MUL_LAT delay line of hilo_entry_t with per-half we-clear inputs; top holds HI/LO, read mux, hazard/forward logic.
// TESTING
// - Reset: drive rst_n=0 mid-flight after mul_valid -> hi=lo=0, busy=0, no later retirement.
// - Latency: mul_valid, mul_hi=0x0001, mul_lo=0x2340 (0x1234*0x0010) -> hi=0x0001, lo=0x2340 exactly MUL_LAT edges later; busy high for MUL_LAT cycles.
// - Hazard: mflo_req cycle after mul_valid(lo=0xBEEF) -> stall=1 until retirement (plus 1 without HILO_FWD_EN); rd_data=0xBEEF, rd_valid single pulse.
// - Order: mul_valid (0x1111,0x2222) then mthi_en mt_data=0xAAAA next cycle -> final hi=0xAAAA, lo=0x2222.
// - Back-to-back: products (0x0001,0x0002),(0x0003,0x0004) consecutive -> hi/lo show 0x0001/0x0002 then 0x0003/0x0004 on successive edges.
// - Dual read: mfhi_req=mflo_req=1, hi=0x5A5A, busy=0 -> stall=0, rd_data=0x5A5A, one rd_valid pulse.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO register unit.
// The optional HILO_FWD_EN build macro is consumed by hilo_unit.
package hilo_pkg;

    localparam int HILO_DATA_W  = 16;
    localparam int HILO_MUL_LAT = 2;

    typedef struct packed {
        logic                   valid;
        logic                   hi_we;
        logic                   lo_we;
        logic [HILO_DATA_W-1:0] hi;
        logic [HILO_DATA_W-1:0] lo;
    } hilo_entry_t;

    // A move-to on a half makes every older product for that half dead.
    function automatic hilo_entry_t clear_we(hilo_entry_t e, logic clr_hi, logic clr_lo);
        hilo_entry_t r;
        r       = e;
        r.hi_we = e.hi_we & ~clr_hi;
        r.lo_we = e.lo_we & ~clr_lo;
        return r;
    endfunction

endpackage

// File: rtl/hilo_pipe.sv
// MUL_LAT-deep delay line of in-flight products; the last stage is presented
// as the entry retiring on the next edge.
module hilo_pipe
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = HILO_MUL_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [HILO_DATA_W-1:0] load_hi,
    input  logic [HILO_DATA_W-1:0] load_lo,
    input  logic                   clr_hi,
    input  logic                   clr_lo,
    output hilo_entry_t            retire,
    output logic                   busy,
    output logic                   busy_young
);

    hilo_entry_t stage_q [MUL_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // A new product is younger than a same-cycle move, so it keeps both enables.
            stage_q[0] <= '{valid: load, hi_we: load, lo_we: load, hi: load_hi, lo: load_lo};
            for (int i = 1; i < MUL_LAT; i++) begin
                stage_q[i] <= clear_we(stage_q[i-1], clr_hi, clr_lo);
            end
        end
    end

    always_comb begin
        busy_young = 1'b0;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            busy_young = busy_young | stage_q[i].valid;
        end
        busy = busy_young | stage_q[MUL_LAT-1].valid;
    end

    assign retire = stage_q[MUL_LAT-1];

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO register unit: retires multiplier products, services
// MTHI/MTLO and MFHI/MFLO, and stalls reads behind in-flight products (HILO_FWD_EN adds bypass).
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W  = HILO_DATA_W,
    parameter int MUL_LAT = HILO_MUL_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mul_valid,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    input  logic              mthi_en,
    input  logic              mtlo_en,
    input  logic [DATA_W-1:0] mt_data,
    input  logic              mfhi_req,
    input  logic              mflo_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
);

    hilo_entry_t       ret;
    logic              busy_young;
    logic              rd_req;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] hi_src;
    logic [DATA_W-1:0] lo_src;

    hilo_pipe #(.MUL_LAT(MUL_LAT)) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (mul_valid),
        .load_hi    (mul_hi),
        .load_lo    (mul_lo),
        .clr_hi     (mthi_en),
        .clr_lo     (mtlo_en),
        .retire     (ret),
        .busy       (busy),
        .busy_young (busy_young)
    );

    assign rd_req = mfhi_req | mflo_req;

`ifdef HILO_FWD_EN
    // Only the retiring entry may be in flight; its value (or a same-cycle move) is bypassed.
    assign hazard = busy_young;
    assign hi_src = mthi_en ? mt_data : ((ret.valid && ret.hi_we) ? ret.hi : hi);
    assign lo_src = mtlo_en ? mt_data : ((ret.valid && ret.lo_we) ? ret.lo : lo);
`else
    assign hazard = busy_young | ret.valid;
    assign hi_src = hi;
    assign lo_src = lo;
`endif

    assign stall  = rd_req & hazard;
    assign accept = rd_req & ~hazard;

    // Moves win over a product retiring on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (mthi_en) begin
                hi <= mt_data;
            end else if (ret.valid && ret.hi_we) begin
                hi <= ret.hi;
            end
            if (mtlo_en) begin
                lo <= mt_data;
            end else if (ret.valid && ret.lo_we) begin
                lo <= ret.lo;
            end
        end
    end

    // A dual request returns HI; the LO request is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= accept;
            if (accept) begin
                rd_data <= mfhi_req ? hi_src : lo_src;
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a retire-time queue model checked every cycle.
module tb_hilo_unit;

    localparam int W   = 16;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mul_valid = 1'b0;
    logic [W-1:0] mul_hi = '0;
    logic [W-1:0] mul_lo = '0;
    logic         mthi_en = 1'b0;
    logic         mtlo_en = 1'b0;
    logic [W-1:0] mt_data = '0;
    logic         mfhi_req = 1'b0;
    logic         mflo_req = 1'b0;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;

    always #5 clk = ~clk;

    hilo_unit #(.DATA_W(W), .MUL_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mul_valid (mul_valid),
        .mul_hi    (mul_hi),
        .mul_lo    (mul_lo),
        .mthi_en   (mthi_en),
        .mtlo_en   (mtlo_en),
        .mt_data   (mt_data),
        .mfhi_req  (mfhi_req),
        .mflo_req  (mflo_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each product carries the cycle number at which it lands in HI/LO.
    typedef struct {
        int           ret;
        logic         hw;
        logic         lw;
        logic [W-1:0] h;
        logic [W-1:0] l;
    } pend_t;

    pend_t        pq[$];
    pend_t        e;
    int           cyc = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_rd_data = '0;
    logic         m_rd_valid = 1'b0;
    logic         m_acc;

    function automatic logic retiring_next();
        return pq.size() > 0 && pq[0].ret == cyc + 1;
    endfunction

    function automatic logic m_hazard();
`ifdef HILO_FWD_EN
        return pq.size() > 1 || (pq.size() == 1 && !retiring_next());
`else
        return pq.size() != 0;
`endif
    endfunction

    function automatic logic [W-1:0] m_read(input logic sel_hi);
`ifdef HILO_FWD_EN
        if (sel_hi) begin
            if (mthi_en) return mt_data;
            if (retiring_next() && pq[0].hw) return pq[0].h;
            return m_hi;
        end
        if (mtlo_en) return mt_data;
        if (retiring_next() && pq[0].lw) return pq[0].l;
        return m_lo;
`else
        return sel_hi ? m_hi : m_lo;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            m_hi       = '0;
            m_lo       = '0;
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
        end else begin
            m_acc = (mfhi_req || mflo_req) && !m_hazard();
            if (m_acc) m_rd_data = m_read(mfhi_req);
            m_rd_valid = m_acc;
            cyc++;
            foreach (pq[i]) begin
                if (mthi_en) pq[i].hw = 1'b0;
                if (mtlo_en) pq[i].lw = 1'b0;
            end
            while (pq.size() > 0 && pq[0].ret == cyc) begin
                e = pq.pop_front();
                if (e.hw) m_hi = e.h;
                if (e.lw) m_lo = e.l;
            end
            if (mthi_en) m_hi = mt_data;
            if (mtlo_en) m_lo = mt_data;
            if (mul_valid) pq.push_back('{cyc + LAT, 1'b1, 1'b1, mul_hi, mul_lo});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_hi", {16'h0, hi}, {16'h0, m_hi});
            chk("m_lo", {16'h0, lo}, {16'h0, m_lo});
            chk("m_busy", {31'h0, busy}, {31'h0, pq.size() != 0});
            chk("m_stall", {31'h0, stall}, {31'h0, (mfhi_req || mflo_req) && m_hazard()});
            chk("m_rd_valid", {31'h0, rd_valid}, {31'h0, m_rd_valid});
            chk("m_rd_data", {16'h0, rd_data}, {16'h0, m_rd_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mul_valid = 1'b0;
        mthi_en   = 1'b0;
        mtlo_en   = 1'b0;
        mfhi_req  = 1'b0;
        mflo_req  = 1'b0;
    endtask

    task automatic mul(input logic [W-1:0] h, input logic [W-1:0] l);
        mul_valid = 1'b1;
        mul_hi    = h;
        mul_lo    = l;
    endtask

    task automatic drain();
        idle();
        repeat (LAT + 1) tick();
    endtask

    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_hi", {16'h0, hi}, 32'h0);
        chk("rst_lo", {16'h0, lo}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        tick();

        // Latency: product lands exactly LAT edges after capture.
        mul(16'h0001, 16'h2340);
        tick();
        idle();
        for (int i = 1; i < LAT; i++) begin
            chk("lat_busy", {31'h0, busy}, 32'h1);
            chk("lat_hi_early", {16'h0, hi}, 32'h0);
            tick();
        end
        chk("lat_busy_last", {31'h0, busy}, 32'h1);
        tick();
        chk("lat_hi", {16'h0, hi}, 32'h0001);
        chk("lat_lo", {16'h0, lo}, 32'h2340);
        chk("lat_busy_done", {31'h0, busy}, 32'h0);
        drain();

        // Hazard: read of LO right behind a multiply.
        mul(16'h0000, 16'hBEEF);
        tick();
        idle();
        mflo_req = 1'b1;
        #1;
        n = 0;
        while (stall && n < 10) begin
            n++;
            tick();
        end
`ifdef HILO_FWD_EN
        chk("haz_stalls", n, LAT - 1);
`else
        chk("haz_stalls", n, LAT);
`endif
        tick();
        mflo_req = 1'b0;
        chk("haz_rd_valid", {31'h0, rd_valid}, 32'h1);
        chk("haz_rd_data", {16'h0, rd_data}, 32'hBEEF);
        tick();
        chk("haz_rd_pulse", {31'h0, rd_valid}, 32'h0);
        drain();

        // Order: a younger MTHI kills the older product's HI half.
        mul(16'h1111, 16'h2222);
        tick();
        idle();
        mthi_en = 1'b1;
        mt_data = 16'hAAAA;
        tick();
        drain();
        chk("ord_hi", {16'h0, hi}, 32'hAAAA);
        chk("ord_lo", {16'h0, lo}, 32'h2222);

        // Back-to-back products retire on successive edges.
        mul(16'h0001, 16'h0002);
        tick();
        mul(16'h0003, 16'h0004);
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("b2b_hi0", {16'h0, hi}, 32'h0001);
        chk("b2b_lo0", {16'h0, lo}, 32'h0002);
        tick();
        chk("b2b_hi1", {16'h0, hi}, 32'h0003);
        chk("b2b_lo1", {16'h0, lo}, 32'h0004);
        drain();

        // Multiply issued alongside MTLO: the move is older, product wins later.
        mul(16'h0102, 16'h0304);
        mtlo_en = 1'b1;
        mt_data = 16'h7777;
        tick();
        idle();
        chk("mtmul_lo_now", {16'h0, lo}, 32'h7777);
        drain();
        chk("mtmul_hi", {16'h0, hi}, 32'h0102);
        chk("mtmul_lo", {16'h0, lo}, 32'h0304);

        // Dual read returns HI with one pulse.
        mthi_en = 1'b1;
        mt_data = 16'h5A5A;
        tick();
        idle();
        mfhi_req = 1'b1;
        mflo_req = 1'b1;
        #1;
        chk("dual_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        chk("dual_rd_valid", {31'h0, rd_valid}, 32'h1);
        chk("dual_rd_data", {16'h0, rd_data}, 32'h5A5A);
        tick();
        chk("dual_pulse", {31'h0, rd_valid}, 32'h0);

        // Read racing a move to the same half.
        mfhi_req = 1'b1;
        mthi_en  = 1'b1;
        mt_data  = 16'h9999;
        tick();
        idle();
`ifdef HILO_FWD_EN
        chk("rdmt_data", {16'h0, rd_data}, 32'h9999);
`else
        chk("rdmt_data", {16'h0, rd_data}, 32'h5A5A);
`endif
        chk("rdmt_hi", {16'h0, hi}, 32'h9999);
        drain();

        // Reset mid-flight discards the product.
        mul(16'hDEAD, 16'hBEEF);
        tick();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (LAT + 1) tick();
        chk("rstf_hi", {16'h0, hi}, 32'h0);
        chk("rstf_lo", {16'h0, lo}, 32'h0);
        chk("rstf_busy", {31'h0, busy}, 32'h0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
